seq_detect_param: RTL and testbench

Parametrised serial sequence detector: a runtime-programmable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, a valid-qualified input stream, a registered (Moore) match pulse and a saturating match counter. It is the next generation of the fixed-pattern detectors in the sequential/FSM set. It sits directly behind a serial bit source and feeds match events to control logic or a status register.

---
 rtl/seq_detect_pkg.sv | 29 ++
 rtl/seq_detect_param_window.sv | 60 ++++++
 rtl/seq_detect_param.sv | 99 +++++++++
 tb/tb_seq_detect_param.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants, FSM encoding and helper functions for the sequence detector.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HUNT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    HUNT = ST_HUNT
  } state_e;

  // Limit a requested pattern length to the physical window size.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Increment a w-bit counter (carried in 32 bits), sticking at its all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= top) ? top : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_param_window.sv
// History window: shift register of received bits, fill counter and masked compare.
module seq_match_window
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               accept,
  input  logic               data_in,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  output logic               hit,
  output logic [LEN_W-1:0]   fill_nxt
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_n, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
  logic               hit_c;

  // Next window contents, length mask and hit decision for the bit being offered.
  always_comb begin
    hist_n = {hist_q[MAX_LEN-2:0], data_in};
    fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < cfg_len);
    end
    hit_c = accept && (cfg_len != '0) && (fill_n >= cfg_len) &&
            (((hist_n ^ cfg_pat) & mask) == '0);
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_n;
      // Non-overlapping mode throws away every consumed bit once a match fires.
      fill_d = (hit_c && !cfg_ovl) ? '0 : fill_n;
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hit      = hit_c;
  assign fill_nxt = fill_n;

endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial sequence detector: config registers, control FSM,
// registered match pulse and saturating match counter around the window.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int  MAX_LEN = DEF_MAX_LEN,
  parameter int  CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_in,
  input  logic               valid_in,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d, len_clamped, fill_nxt;
  logic               cfg_ovl_q, cfg_ovl_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  state_e             state_q, state_d;
  logic               accept, hit;

  assign accept = valid_in && !load;

  seq_match_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load),
    .accept   (accept),
    .data_in  (data_in),
    .cfg_pat  (cfg_pat_q),
    .cfg_len  (cfg_len_q),
    .cfg_ovl  (cfg_ovl_q),
    .hit      (hit),
    .fill_nxt (fill_nxt)
  );

  // Config load, FSM transitions, match pulse and counter update.
  always_comb begin
    len_clamped   = LEN_W'(clamp_len(32'(pat_len), MAX_LEN));
    cfg_pat_d     = cfg_pat_q;
    cfg_len_d     = cfg_len_q;
    cfg_ovl_d     = cfg_ovl_q;
    match_d       = 1'b0;
    match_count_d = match_count_q;
    state_d       = state_q;
    if (load) begin
      cfg_pat_d     = pattern;
      cfg_len_d     = len_clamped;
      cfg_ovl_d     = overlap;
      match_count_d = '0;
      state_d       = (len_clamped == '0) ? IDLE : FILL;
    end else if (accept) begin
      match_d = hit;
      if (hit) begin
        match_count_d = CNT_W'(sat_inc(32'(match_count_q), CNT_W));
      end
      if (cfg_len_q == '0)           state_d = IDLE;
      else if (hit && !cfg_ovl_q)    state_d = FILL;
      else if (fill_nxt >= cfg_len_q) state_d = HUNT;
      else                           state_d = FILL;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pat_q     <= '0;
      cfg_len_q     <= '0;
      cfg_ovl_q     <= 1'b1;
      match_q       <= 1'b0;
      match_count_q <= '0;
      state_q       <= IDLE;
    end else begin
      cfg_pat_q     <= cfg_pat_d;
      cfg_len_q     <= cfg_len_d;
      cfg_ovl_q     <= cfg_ovl_d;
      match_q       <= match_d;
      match_count_q <= match_count_d;
      state_q       <= state_d;
    end
  end

  assign match       = match_q;
  assign match_count = match_count_q;
  assign armed       = (cfg_len_q != '0);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a CNT_W=2 instance.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n, data_in, valid_in, load, overlap;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               match, armed, match_s, armed_s;
  logic [7:0]         count;
  logic [1:0]         count_s;
  int                 total = 0;
  int                 bad   = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in), .load(load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
    .match(match), .match_count(count), .armed(armed)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in), .load(load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
    .match(match_s), .match_count(count_s), .armed(armed_s)
  );

  task automatic send(input logic b);
    @(negedge clk);
    data_in  = b;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
    @(negedge clk);
    load    = 1'b1;
    pattern = pat;
    pat_len = len;
    overlap = ovl;
    @(posedge clk);
    #1;
    load     = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = 1'b0; valid_in = 1'b0; load = 1'b0;
    overlap = 1'b0; pattern = '0; pat_len = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", match); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b want=0", armed); end
    total++; if (count_s !== 2'd0) begin bad++; $display("FAIL reset_count_sat got=%0d want=0", count_s); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] s, e;
    s = 7'b1011011; e = 7'b0001001;
    do_load(8'b1011, 4, 1'b1);
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL ovl_armed got=%b want=1", armed); end
    for (int i = 6; i >= 0; i--) begin
      send(s[i]);
      total++; if (match !== e[i]) begin bad++; $display("FAIL ovl_match bit%0d got=%b want=%b", 7 - i, match, e[i]); end
    end
    total++; if (count !== 8'd2) begin bad++; $display("FAIL ovl_count got=%0d want=2", count); end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] s, e;
    logic [6:0] s2, e2;
    s = 8'b10111011; e = 8'b00010001;
    do_load(8'b1011, 4, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      send(s[i]);
      total++; if (match !== e[i]) begin bad++; $display("FAIL novl_match bit%0d got=%b want=%b", 8 - i, match, e[i]); end
    end
    s2 = 7'b1011011; e2 = 7'b0001000;
    do_load(8'b1011, 4, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      send(s2[i]);
      total++; if (match !== e2[i]) begin bad++; $display("FAIL novl2_match bit%0d got=%b want=%b", 7 - i, match, e2[i]); end
    end
    total++; if (count !== 8'd1) begin bad++; $display("FAIL novl2_count got=%0d want=1", count); end
  endtask

  task automatic test_back_to_back();
    do_load(8'hFF, 8, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      send(1'b1);
      total++; if (match !== (i >= 8)) begin bad++; $display("FAIL b2b_match bit%0d got=%b want=%b", i, match, (i >= 8)); end
    end
    total++; if (count !== 8'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", count); end
  endtask

  task automatic test_gap();
    do_load(8'b1011, 4, 1'b1);
    send(1'b1);
    send(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      total++; if (match !== 1'b0) begin bad++; $display("FAIL gap_match idle%0d got=%b want=0", i, match); end
    end
    send(1'b1);
    total++; if (match !== 1'b0) begin bad++; $display("FAIL gap_match bit3 got=%b want=0", match); end
    send(1'b1);
    total++; if (match !== 1'b1) begin bad++; $display("FAIL gap_match bit4 got=%b want=1", match); end
    idle_cycle();
    total++; if (match !== 1'b0) begin bad++; $display("FAIL gap_drop got=%b want=0", match); end
    total++; if (count !== 8'd1) begin bad++; $display("FAIL gap_count got=%0d want=1", count); end
  endtask

  task automatic test_disable_clamp();
    logic [7:0] s;
    do_load(8'b1011, 0, 1'b1);
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL dis_armed got=%b want=0", armed); end
    s = 8'b10111011;
    for (int i = 7; i >= 0; i--) begin
      send(s[i]);
      total++; if (match !== 1'b0) begin bad++; $display("FAIL dis_match bit%0d got=%b want=0", 8 - i, match); end
    end
    // Length 15 must behave as 8: only the eighth bit completes 8'hA5.
    do_load(8'hA5, 15, 1'b1);
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL clamp_armed got=%b want=1", armed); end
    s = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send(s[i]);
      total++; if (match !== (i == 0)) begin bad++; $display("FAIL clamp_match bit%0d got=%b want=%b", 8 - i, match, (i == 0)); end
    end
  endtask

  task automatic test_saturate();
    do_load(8'b1, 1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1);
      total++; if (count_s !== ((i > 3) ? 2'd3 : 2'(i))) begin bad++; $display("FAIL sat_count bit%0d got=%0d want=%0d", i, count_s, (i > 3) ? 3 : i); end
    end
    total++; if (count !== 8'd5) begin bad++; $display("FAIL sat_wide_count got=%0d want=5", count); end
  endtask

  task automatic test_load_midstream();
    logic [6:0] s, e;
    do_load(8'b1011, 4, 1'b1);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    send(1'b1); send(1'b0); send(1'b1);
    // Reload with a bit offered in the same cycle; that bit must be dropped.
    @(negedge clk);
    load = 1'b1; valid_in = 1'b1; data_in = 1'b1;
    pattern = 8'b1011; pat_len = 4; overlap = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0; valid_in = 1'b0;
    total++; if (count !== 8'd0) begin bad++; $display("FAIL ld_count got=%0d want=0", count); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL ld_match got=%b want=0", match); end
    s = 7'b0111011; e = 7'b0000001;
    for (int i = 6; i >= 0; i--) begin
      send(s[i]);
      total++; if (match !== e[i]) begin bad++; $display("FAIL ld_after bit%0d got=%b want=%b", 7 - i, match, e[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    do_load(8'b1011, 4, 1'b1);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    send(1'b1); send(1'b0); send(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (match !== 1'b0) begin bad++; $display("FAIL rst_mid_match got=%b want=0", match); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL rst_mid_count got=%0d want=0", count); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL rst_mid_armed got=%b want=0", armed); end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1);
    total++; if (match !== 1'b0) begin bad++; $display("FAIL rst_after_match got=%b want=0", match); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL rst_after_armed got=%b want=0", armed); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_back_to_back();
    test_gap();
    test_disable_clamp();
    test_saturate();
    test_load_midstream();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
